// File: rtl/dcache_if.sv
// dcache_if: CPU-side request/response and memory-side strobes of the direct-mapped data cache
interface dcache_if;
  logic        cpu_read;
  logic        cpu_write;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_ack;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic        mem_ready;
  logic [15:0] hit_count;
  logic [15:0] miss_count;
  modport master (
    output cpu_read, cpu_write, cpu_addr, cpu_wdata, mem_ready,
    input  cpu_rdata, cpu_ack, mem_read, mem_write, mem_addr, hit_count, miss_count
  );
  modport slave (
    input  cpu_read, cpu_write, cpu_addr, cpu_wdata, mem_ready,
    output cpu_rdata, cpu_ack, mem_read, mem_write, mem_addr, hit_count, miss_count
  );
endinterface

// File: rtl/dcache_dm.sv
// dcache_dm: direct-mapped write-through no-write-allocate data cache with line refill and hit/miss counters
module dcache_dm #(
  parameter int INDEX_BITS  = 2,
  parameter int OFFSET_BITS = 2,
  parameter int MEM_CYCLES  = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  dcache_if.slave    bus,
  inout  wire [15:0] mem_data
);
  localparam int LO    = INDEX_BITS + OFFSET_BITS;
  localparam int TW    = 16 - LO;
  localparam int LINES = 1 << INDEX_BITS;
  localparam int WORDS = 1 << OFFSET_BITS;
  localparam int CW    = $clog2(MEM_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, REFILL, WRITE, RESP} state_t;
  state_t                 state;
  logic [LINES-1:0]       valid_q;
  logic [TW-1:0]          tag_q  [LINES];
  logic [15:0]            data_q [LINES][WORDS];
  logic [CW-1:0]          cyc;
  logic [OFFSET_BITS-1:0] word_cnt;
  logic [15:0]            addr_q, wdata_q, rdata_q, mem_addr_q, hit_q, miss_q;
  logic                   ack_q, mem_read_q, mem_write_q;
  logic [TW-1:0]          tag, r_tag;
  logic [INDEX_BITS-1:0]  idx, r_idx;
  logic [OFFSET_BITS-1:0] off, r_off;
  logic                   hit, start, wr_hit_go, last_cyc, last_word, refill_done;
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return v + {15'd0, v != 16'hFFFF};
  endfunction
  assign {tag, idx, off}       = bus.cpu_addr;
  assign {r_tag, r_idx, r_off} = addr_q;
  assign hit         = valid_q[idx] && tag_q[idx] == tag;
  assign start       = state == IDLE && !ack_q;
  assign wr_hit_go   = start && bus.cpu_write && bus.mem_ready && hit;
  assign last_cyc    = cyc == CW'(MEM_CYCLES - 1);
  assign last_word   = word_cnt == '1;
  assign refill_done = state == REFILL && last_cyc && last_word;
  assign bus.cpu_rdata  = rdata_q;
  assign bus.cpu_ack    = ack_q;
  assign bus.mem_read   = mem_read_q;
  assign bus.mem_write  = mem_write_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.hit_count  = hit_q;
  assign bus.miss_count = miss_q;
  assign mem_data = mem_write_q ? wdata_q : 16'hzzzz;
  // line storage: write hits update in place, refills fill word by word, tag committed with the last word
  always_ff @(posedge clk) begin
    if (wr_hit_go) data_q[idx][off] <= bus.cpu_wdata;
    if (state == REFILL && last_cyc) data_q[r_idx][word_cnt] <= mem_data;
    if (refill_done) tag_q[r_idx] <= r_tag;
  end
  // control FSM with registered memory strobes, ack pulse, read data and saturating counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      valid_q     <= '0;
      cyc         <= '0;
      word_cnt    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      hit_q       <= '0;
      miss_q      <= '0;
      ack_q       <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ack_q <= 1'b0;
          if (start && bus.cpu_write) begin
            if (bus.mem_ready) begin
              state       <= WRITE;
              mem_write_q <= 1'b1;
              mem_addr_q  <= bus.cpu_addr;
              wdata_q     <= bus.cpu_wdata;
              cyc         <= '0;
              if (hit) hit_q <= sat_inc(hit_q);
              else miss_q <= sat_inc(miss_q);
            end
          end else if (start && bus.cpu_read) begin
            if (hit) begin
              rdata_q <= data_q[idx][off];
              ack_q   <= 1'b1;
              hit_q   <= sat_inc(hit_q);
            end else if (bus.mem_ready) begin
              state        <= REFILL;
              valid_q[idx] <= 1'b0;
              mem_read_q   <= 1'b1;
              mem_addr_q   <= {bus.cpu_addr[15:OFFSET_BITS], OFFSET_BITS'(0)};
              addr_q       <= bus.cpu_addr;
              word_cnt     <= '0;
              cyc          <= '0;
              miss_q       <= sat_inc(miss_q);
            end
          end
        end
        REFILL: begin
          if (!last_cyc) cyc <= cyc + CW'(1);
          else if (!last_word) begin
            cyc        <= '0;
            word_cnt   <= word_cnt + OFFSET_BITS'(1);
            mem_addr_q <= mem_addr_q + 16'd1;
          end else begin
            mem_read_q     <= 1'b0;
            valid_q[r_idx] <= 1'b1;
            rdata_q        <= (r_off == word_cnt) ? mem_data : data_q[r_idx][r_off];
            ack_q          <= 1'b1;
            state          <= RESP;
          end
        end
        WRITE: begin
          if (!last_cyc) cyc <= cyc + CW'(1);
          else begin
            mem_write_q <= 1'b0;
            ack_q       <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          ack_q <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
